// File: rtl/ex_branch_pkg.sv
// Shared types for the EX-stage branch resolution slice: branch opcode
// encoding, squash counter width and the branch-offset helper.
package ex_branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BEQ     = 3'd1,
    BNE     = 3'd2,
    BLEZ    = 3'd3,
    BGTZ    = 3'd4,
    BLTZ    = 3'd5,
    BGEZ    = 3'd6
  } br_op_e;

  // Wide enough for up to 3 squash slots.
  localparam int SQ_CNT_W = 2;

  // Sign-extend a 16-bit word offset and convert it to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch evaluation: zero flag, taken flag and branch target
// computed from the ALU result, opcode, PC+4 and immediate.
module branch_cond_eval
  import ex_branch_pkg::*;
(
  input  logic [31:0] alu_result_i,
  input  logic [2:0]  br_op_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [15:0] imm_i,
  output logic        zero_o,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic any_set;
  logic neg;

  or1x32_1 u_zero_or (
    .a_i (alu_result_i),
    .y_o (any_set)
  );

  assign zero_o   = ~any_set;
  assign neg      = alu_result_i[31];
  // Target wraps modulo 2^32 without any flag.
  assign target_o = pc_plus4_i + branch_offset(imm_i);

  // Taken decision per opcode; unused encodings never branch.
  always_comb begin
    taken_o = 1'b0;
    case (br_op_i)
      BEQ:     taken_o = zero_o;
      BNE:     taken_o = ~zero_o;
      BLEZ:    taken_o = neg | zero_o;
      BGTZ:    taken_o = ~neg & ~zero_o;
      BLTZ:    taken_o = neg;
      BGEZ:    taken_o = ~neg;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/or1x32_1.sv
// 32-input OR-reduction cell used for the zero detect.
module or1x32_1 (
  input  logic [31:0] a_i,
  output logic        y_o
);

  assign y_o = |a_i;

endmodule

// File: rtl/ex_branch_resolve_stage.sv
// EX->MEM pipeline register with branch resolution, one-cycle PC redirect
// and squashing of younger wrong-path instructions.
//
// Optional feature macro: BRANCH_DELAY_SLOT_EN. When defined, the first
// instruction accepted after a taken branch is the delay slot: it is
// forwarded (its own branch is not honoured) and only the following
// SQUASH_SLOTS-1 accepts are dropped.
//
// Handshake: an instruction transfers into the stage when in_valid && in_ready;
// an entry leaves when out_valid && out_ready. in_ready is combinational
// (!out_valid || out_ready) so a drain and a new accept share one edge.
// Once out_valid is high and out_ready is low, every out_* holds stable.
module ex_branch_resolve_stage
  import ex_branch_pkg::*;
#(
  parameter int SQUASH_SLOTS = 2,
  parameter int DW           = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       alu_result,
  input  logic [2:0]          br_op,
  input  logic [31:0]         pc_plus4,
  input  logic [15:0]         imm,
  input  logic [31:0]         payload,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_result,
  output logic [31:0]         out_payload,
  output logic                out_zero,
  output logic                redirect,
  output logic [31:0]         redirect_pc,
  output logic [SQ_CNT_W-1:0] squash_cnt_o
);

  localparam logic [SQ_CNT_W-1:0] SLOTS_L = SQ_CNT_W'(SQUASH_SLOTS);

  logic                out_valid_q;
  logic [DW-1:0]       out_result_q;
  logic [31:0]         out_payload_q;
  logic                out_zero_q;
  logic                redirect_q;
  logic [31:0]         redirect_pc_q;
  logic [SQ_CNT_W-1:0] squash_cnt_q;

  logic        zero;
  logic        taken;
  logic [31:0] target;
  logic        accept;
  logic        squashing;

  branch_cond_eval u_eval (
    .alu_result_i (alu_result),
    .br_op_i      (br_op),
    .pc_plus4_i   (pc_plus4),
    .imm_i        (imm),
    .zero_o       (zero),
    .taken_o      (taken),
    .target_o     (target)
  );

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

`ifdef BRANCH_DELAY_SLOT_EN
  logic ds_pend_q;
  // The delay slot is never squashed, even with squash slots still pending.
  assign squashing = (squash_cnt_q != '0) & ~ds_pend_q;
`else
  assign squashing = (squash_cnt_q != '0);
`endif

  // Output register, redirect pulse and squash bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_payload_q <= '0;
      out_zero_q    <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      squash_cnt_q  <= '0;
`ifdef BRANCH_DELAY_SLOT_EN
      ds_pend_q     <= 1'b0;
`endif
    end else begin
      // Redirect is a single-cycle pulse; the PC reads zero otherwise.
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      if (accept) begin
        if (squashing) begin
          // Wrong-path instruction: drop it. Accepting implies the old
          // entry (if any) drained this edge.
          squash_cnt_q <= squash_cnt_q - 1'b1;
          out_valid_q  <= 1'b0;
        end else begin
          out_valid_q   <= 1'b1;
          out_result_q  <= alu_result;
          out_payload_q <= payload;
          out_zero_q    <= zero;
`ifdef BRANCH_DELAY_SLOT_EN
          if (ds_pend_q) begin
            ds_pend_q <= 1'b0;
          end else if (taken) begin
            redirect_q    <= 1'b1;
            redirect_pc_q <= target;
            squash_cnt_q  <= SLOTS_L - 1'b1;
            ds_pend_q     <= 1'b1;
          end
`else
          if (taken) begin
            redirect_q    <= 1'b1;
            redirect_pc_q <= target;
            squash_cnt_q  <= SLOTS_L;
          end
`endif
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_payload  = out_payload_q;
  assign out_zero     = out_zero_q;
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign squash_cnt_o = squash_cnt_q;

endmodule

// File: tb/tb_ex_branch_resolve_stage.sv
// Directed bench for ex_branch_resolve_stage: a table of per-cycle vectors
// plus hand-written sequences for reset, backpressure and squash corners.
module tb_ex_branch_resolve_stage;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit BDS_EN = 1'b1;
`else
  localparam bit BDS_EN = 1'b0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [2:0]  br_op = '0;
  logic [31:0] pc_plus4 = '0;
  logic [15:0] imm = '0;
  logic [31:0] payload = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [31:0] out_payload;
  logic        out_zero;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  squash_cnt_o;

  ex_branch_resolve_stage #(.SQUASH_SLOTS(2), .DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .br_op        (br_op),
    .pc_plus4     (pc_plus4),
    .imm          (imm),
    .payload      (payload),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_payload  (out_payload),
    .out_zero     (out_zero),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .squash_cnt_o (squash_cnt_o)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic        vld;
    logic [2:0]  op;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic [31:0] pay;
    logic        e_ov;
    logic [31:0] e_res;
    logic [31:0] e_pay;
    logic        e_zero;
    logic        e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic vld, input logic [2:0] op,
                              input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [15:0] imm_v, input logic [31:0] pay,
                              input logic e_ov, input logic [31:0] e_res,
                              input logic [31:0] e_pay, input logic e_zero,
                              input logic e_redir, input logic [31:0] e_rpc);
    vec_t v;
    v.vld = vld; v.op = op; v.alu = alu; v.pc4 = pc4; v.imm = imm_v; v.pay = pay;
    v.e_ov = e_ov; v.e_res = e_res; v.e_pay = e_pay; v.e_zero = e_zero;
    v.e_redir = e_redir; v.e_rpc = e_rpc;
    return v;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver: apply inputs on the falling edge
  task automatic drive(input logic vld, input logic [2:0] op, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [15:0] imm_v,
                       input logic [31:0] pay, input logic ordy);
    @(negedge clk);
    in_valid   = vld;
    br_op      = op;
    alu_result = alu;
    pc_plus4   = pc4;
    imm        = imm_v;
    payload    = pay;
    out_ready  = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [31:0] res,
                         input logic [31:0] pay, input logic z, input logic rd,
                         input logic [31:0] rpc);
    chk({tag, " out_valid"},   32'(out_valid), 32'(ov));
    chk({tag, " out_result"},  out_result, res);
    chk({tag, " out_payload"}, out_payload, pay);
    chk({tag, " out_zero"},    32'(out_zero), 32'(z));
    chk({tag, " redirect"},    32'(redirect), 32'(rd));
    chk({tag, " redirect_pc"}, redirect_pc, rpc);
  endtask

  initial begin
    // Expected values below are hand-computed for SQUASH_SLOTS=2.
    vecs[0]  = mk(1, 3'd0, 32'h0000_1234, 32'h0,   16'h0,    32'hA0, 1, 32'h1234, 32'hA0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 3'd1, 32'h0,         32'h100, 16'h0004, 32'hA1, 1, 32'h0,    32'hA1, 1, 1, 32'h110);
    vecs[2]  = BDS_EN ? mk(1, 3'd0, 32'h5, 32'h0, 16'h0, 32'hA2, 1, 32'h5, 32'hA2, 0, 0, 32'h0)
                      : mk(1, 3'd0, 32'h5, 32'h0, 16'h0, 32'hA2, 0, 32'h0, 32'hA1, 1, 0, 32'h0);
    vecs[3]  = BDS_EN ? mk(1, 3'd0, 32'h6, 32'h0, 16'h0, 32'hA3, 0, 32'h5, 32'hA2, 0, 0, 32'h0)
                      : mk(1, 3'd0, 32'h6, 32'h0, 16'h0, 32'hA3, 0, 32'h0, 32'hA1, 1, 0, 32'h0);
    vecs[4]  = mk(1, 3'd2, 32'h1,         32'h200, 16'hFFFF, 32'hA4, 1, 32'h1,    32'hA4, 0, 1, 32'h1FC);
    vecs[5]  = mk(0, 3'd0, 32'h99,        32'h0,   16'h0,    32'hA5, 0, 32'h1,    32'hA4, 0, 0, 32'h0);
    vecs[6]  = BDS_EN ? mk(1, 3'd0, 32'h7, 32'h0, 16'h0, 32'hA6, 1, 32'h7, 32'hA6, 0, 0, 32'h0)
                      : mk(1, 3'd0, 32'h7, 32'h0, 16'h0, 32'hA6, 0, 32'h1, 32'hA4, 0, 0, 32'h0);
    vecs[7]  = BDS_EN ? mk(1, 3'd0, 32'h8, 32'h0, 16'h0, 32'hA7, 0, 32'h7, 32'hA6, 0, 0, 32'h0)
                      : mk(1, 3'd0, 32'h8, 32'h0, 16'h0, 32'hA7, 0, 32'h1, 32'hA4, 0, 0, 32'h0);
    vecs[8]  = mk(1, 3'd4, 32'h8000_0000, 32'h300, 16'h0008, 32'hA8, 1, 32'h8000_0000, 32'hA8, 0, 0, 32'h0);
    vecs[9]  = mk(1, 3'd5, 32'h7FFF_FFFF, 32'h300, 16'h0008, 32'hA9, 1, 32'h7FFF_FFFF, 32'hA9, 0, 0, 32'h0);
    vecs[10] = mk(1, 3'd7, 32'h0,         32'h300, 16'h0008, 32'hAA, 1, 32'h0,    32'hAA, 1, 0, 32'h0);
    vecs[11] = mk(1, 3'd3, 32'h1,         32'h300, 16'h0008, 32'hAB, 1, 32'h1,    32'hAB, 0, 0, 32'h0);
    vecs[12] = mk(1, 3'd6, 32'h0,  32'hFFFF_FFFC, 16'h0001, 32'hAC, 1, 32'h0,    32'hAC, 1, 1, 32'h0);

    // Reset held two cycles with a valid taken branch on the input
    drive(1, 3'd1, 32'h0, 32'h100, 16'h4, 32'hDEAD, 1);
    rst_n = 1'b0;
    step();
    step();
    chk_out("reset", 0, 32'h0, 32'h0, 0, 0, 32'h0);
    chk("reset squash_cnt", 32'(squash_cnt_o), 32'h0);

    // Table-driven sequence
    drive(0, 3'd0, 32'h0, 32'h0, 16'h0, 32'h0, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].vld, vecs[i].op, vecs[i].alu, vecs[i].pc4, vecs[i].imm, vecs[i].pay, 1);
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'h1);
      step();
      chk_out($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_res, vecs[i].e_pay,
              vecs[i].e_zero, vecs[i].e_redir, vecs[i].e_rpc);
    end

    // Reset asserted mid-squash abandons the pending squash
    chk("pre-reset squash_cnt", 32'(squash_cnt_o), BDS_EN ? 32'h1 : 32'h2);
    drive(1, 3'd0, 32'h44, 32'h0, 16'h0, 32'hB4, 1);
    rst_n = 1'b0;
    step();
    chk("midreset squash_cnt", 32'(squash_cnt_o), 32'h0);
    chk_out("midreset", 0, 32'h0, 32'h0, 0, 0, 32'h0);
    drive(1, 3'd0, 32'h55, 32'h0, 16'h0, 32'hB5, 1);
    rst_n = 1'b1;
    step();
    chk_out("post-reset accept", 1, 32'h55, 32'hB5, 0, 0, 32'h0);

    // Backpressure: three stalled cycles, then drain+accept on one edge
    for (int c = 0; c < 3; c++) begin
      drive(1, 3'd0, 32'h66, 32'h0, 16'h0, 32'hB6, 0);
      #1;
      chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'h0);
      step();
      chk_out($sformatf("bp%0d", c), 1, 32'h55, 32'hB5, 0, 0, 32'h0);
    end
    drive(1, 3'd0, 32'h66, 32'h0, 16'h0, 32'hB6, 1);
    #1;
    chk("release in_ready", 32'(in_ready), 32'h1);
    step();
    chk_out("release", 1, 32'h66, 32'hB6, 0, 0, 32'h0);
    drive(0, 3'd0, 32'h0, 32'h0, 16'h0, 32'h0, 1);
    step();
    chk("drain out_valid", 32'(out_valid), 32'h0);

    // Taken branch arriving while squash_cnt==1 is dropped without redirect
    drive(1, 3'd1, 32'h0, 32'h400, 16'h0, 32'hC0, 1);
    step();
    chk_out("sq br0", 1, 32'h0, 32'hC0, 1, 1, 32'h400);
    drive(1, 3'd0, 32'h77, 32'h0, 16'h0, 32'hC1, 1);
    step();
    if (BDS_EN) chk_out("sq slot", 1, 32'h77, 32'hC1, 0, 0, 32'h0);
    else        chk_out("sq slot", 0, 32'h0, 32'hC0, 1, 0, 32'h0);
    chk("sq slot squash_cnt", 32'(squash_cnt_o), 32'h1);
    drive(1, 3'd1, 32'h0, 32'h500, 16'h0, 32'hC2, 1);
    step();
    chk("sq br1 redirect", 32'(redirect), 32'h0);
    chk("sq br1 redirect_pc", redirect_pc, 32'h0);
    chk("sq br1 out_valid", 32'(out_valid), 32'h0);
    chk("sq br1 squash_cnt", 32'(squash_cnt_o), 32'h0);
    drive(1, 3'd0, 32'h88, 32'h0, 16'h0, 32'hC3, 1);
    step();
    chk_out("sq fwd", 1, 32'h88, 32'hC3, 0, 0, 32'h0);

    drive(0, 3'd0, 32'h0, 32'h0, 16'h0, 32'h0, 1);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ex_branch_resolve_stage.md
Name: ex_branch_resolve_stage

Overview:
- Pipeline register between the EX-stage ALU and the MEM stage.
- Takes the 32-bit ALU result and computes the zero flag with the team's 32-input OR-reduction cell (or1x32_1).
- Resolves conditional branches and drives a one-cycle PC redirect.
- Squashes younger wrong-path instructions and passes surviving instructions to MEM over a valid/ready handshake.

Parameters:
- SQUASH_SLOTS, default 2: number of younger instructions dropped after a taken branch (1..3).
- DW, default 32: datapath width. Fixed at 32 because the zero detect is 32-input.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  EX holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_result  in  32  ALU output. rs-rt for BEQ/BNE; rs-0 for sign branches.
- br_op  in  3  branch opcode (package enum).
- pc_plus4  in  32  PC+4 of the instruction.
- imm  in  16  branch offset, sign-extended internally.
- payload  in  32  opaque MEM-stage control/data word, passed through.
- out_valid  out  1  MEM-side valid.
- out_ready  in  1  MEM can accept.
- out_result  out  32  registered alu_result.
- out_payload  out  32  registered payload.
- out_zero  out  1  registered zero flag.
- redirect  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  32  branch target while redirect is 1.

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0, redirect=0, redirect_pc=0, out_result=0, out_payload=0, out_zero=0, squash_cnt=0. Applies mid-operation: pending squash is abandoned.
- in_ready = !out_valid || out_ready. This is combinational; no bubble when draining.
- Accept event: in_valid && in_ready.
- zero = ~|alu_result.
- Taken condition per br_op:
  - BR_NONE: never taken.
  - BEQ: zero.
  - BNE: !zero.
  - BLEZ: alu_result[31] || zero.
  - BGTZ: !alu_result[31] && !zero.
  - BLTZ: alu_result[31].
  - BGEZ: !alu_result[31].
  - Codes 7 and above: not taken.
- Target = pc_plus4 + (sext(imm) << 2), mod 2^32. Wrap-around is allowed and not flagged.
- Accept with squash_cnt==0:
  - Output registers load next cycle; out_valid=1.
  - If taken: redirect=1 for exactly that cycle, redirect_pc=target, squash_cnt=SQUASH_SLOTS.
- Accept with squash_cnt>0:
  - Instruction is dropped and squash_cnt decrements.
  - out_valid follows the normal drain rule: it clears if out_ready, otherwise holds the old entry.
  - A taken branch that is itself squashed produces no redirect.
- No accept, out_valid && out_ready: out_valid=0 next cycle.
- out_valid && !out_ready: all out_* registers hold stable.
- Latency: one cycle from accept to out_valid and redirect.
- redirect is never asserted in two consecutive cycles.
- redirect_pc reads 0 when redirect=0.
- Simultaneous accept and drain: the new entry replaces the old one in the same edge.

Optional Feature:
- Macro BRANCH_DELAY_SLOT_EN.
- Defined: the first instruction accepted after a taken branch (MIPS delay slot) is forwarded, not squashed; squashing then covers the next SQUASH_SLOTS-1 accepts.
- Undefined: all SQUASH_SLOTS accepts are squashed.

Decomposition:
- Package ex_branch_pkg holds:
  - br_op enum (3-bit; BR_NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, BLTZ=5, BGEZ=6).
  - SQUASH counter width.
- One natural sub-module: branch_cond_eval (combinational; taken flag and target from alu_result, br_op, pc_plus4, imm). It instantiates or1x32_1 for zero.
- The stage module holds the register, handshake and squash counter.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1 -> out_valid=0, redirect=0, all out_* 0.
- BEQ, alu_result=0, pc_plus4=0x100, imm=0x0004 -> next cycle out_zero=1, redirect=1, redirect_pc=0x110; the next 2 accepts are dropped (1 with BRANCH_DELAY_SLOT_EN).
- BNE, alu_result=0x00000001 -> redirect=1. BGTZ, alu_result=0x80000000 -> no redirect, out_zero=0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and out_* stable; release -> drains and accepts the next item with no bubble.
- Taken branch arriving while squash_cnt=1 -> dropped, no redirect; squash_cnt reaches 0; the following instruction is forwarded.
- Wrap: pc_plus4=0xFFFFFFFC, imm=0x0001, BGEZ, alu_result=0 -> redirect_pc=0x00000000. Reset asserted mid-squash -> squash_cnt=0, next accept forwarded.
